alu_ctrl_issue: RTL and testbench

//  Producer side of the 3-bit ALUCtrl interface consumed by the EX-stage ALU.

---
 rtl/alu_ctrl_pkg.sv | 45 ++++
 rtl/alu_ctrl_decode.sv | 57 +++++
 rtl/alu_ctrl_issue.sv | 106 ++++++++++
 tb/tb_alu_ctrl_issue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALUCtrl operation codes, instruction field constants and issue FSM encoding.
// Shared by the decoder and the issue stage; no logic of its own.
// Nothing here carries state or flow control.
package alu_ctrl_pkg;

  // ALU operation codes driven on ALUCtrl; 3'b111 is reserved and never produced
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;

  // Major opcodes
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 variants of OP_REG
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // funct3 selectors
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Decoder result
  typedef struct packed {
    logic [2:0] code;
    logic       illegal;
  } dec_t;

  // Issue FSM: IDLE accepts from ID, MULW holds a multi-cycle MUL
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULW = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purpose: map opcode/funct3/funct7 to an ALU operation code plus an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the issue stage decides when the result is used.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  // Anything not matched below falls through to PASS and is flagged illegal
  always_comb begin
    dec.code    = ALU_PASS;
    dec.illegal = 1'b1;
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          dec.illegal = 1'b0;
          case (funct3)
            F3_ADD:  dec.code = ALU_ADD;
            F3_AND:  dec.code = ALU_AND;
            F3_OR:   dec.code = ALU_OR;
            F3_XOR:  dec.code = ALU_XOR;
            default: dec.illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.code    = ALU_SUB;
          dec.illegal = 1'b0;
        end else if (funct7 == F7_MUL && funct3 == F3_ADD) begin
          dec.code    = ALU_MUL;
          dec.illegal = 1'b0;
        end
      end
      OP_IMM: begin
        // only addi is supported among the immediate forms
        if (funct3 == F3_ADD) begin
          dec.code    = ALU_ADD;
          dec.illegal = 1'b0;
        end
      end
      OP_LOAD, OP_STORE: begin
        // address generation: base + offset, any width
        dec.code    = ALU_ADD;
        dec.illegal = 1'b0;
      end
      OP_BRANCH: begin
        // compare by subtraction
        dec.code    = ALU_SUB;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Purpose: ID/EX control register for ALUCtrl; sequences multi-cycle MUL issue.
// Latency: one edge from accepted ID input to ALUCtrl_o; MUL stays on ALUCtrl_o for MUL_CYCLES cycles.
// Backpressure: busy_o holds ID during MUL; stall_i freezes all state; flush_i clears and drops the input.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic [2:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       commit_o,
  output logic       busy_o,
  output logic       illegal_o
);

  localparam int                CNT_W     = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  localparam bit                MUL_MULTI = (MUL_CYCLES > 1);

  // Reject out-of-range MUL latency at elaboration
  if (MUL_CYCLES < 1 || MUL_CYCLES > 16) begin : g_bad_mul_cycles
    $error("alu_ctrl_issue: MUL_CYCLES must be within 1..16");
  end

  dec_t             dec;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  alu_ctrl_decode u_decode (
    .opcode (opcode_i),
    .funct3 (funct3_i),
    .funct7 (funct7_i),
    .dec    (dec)
  );

  // Issue FSM and output registers: flush beats stall beats normal update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ALUCtrl_o <= ALU_PASS;
      valid_o   <= 1'b0;
      commit_o  <= 1'b0;
      busy_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      // aborts any MUL in flight; the presented instruction is dropped
      state     <= ST_IDLE;
      cnt       <= '0;
      ALUCtrl_o <= ALU_PASS;
      valid_o   <= 1'b0;
      commit_o  <= 1'b0;
      busy_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            ALUCtrl_o <= dec.code;
            valid_o   <= 1'b1;
            illegal_o <= dec.illegal;
            if (MUL_MULTI && dec.code == ALU_MUL) begin
              cnt      <= CNT_INIT;
              busy_o   <= 1'b1;
              commit_o <= 1'b0;
              state    <= ST_MULW;
            end else begin
              busy_o   <= 1'b0;
              commit_o <= 1'b1;
            end
          end else begin
            ALUCtrl_o <= ALU_PASS;
            valid_o   <= 1'b0;
            commit_o  <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
          end
        end
        ST_MULW: begin
          // ID inputs are ignored; the MUL code is held until its last cycle
          ALUCtrl_o <= ALU_MUL;
          valid_o   <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            commit_o <= 1'b1;
            busy_o   <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: two instances (MUL_CYCLES=4 and 1) share one stimulus stream.
// A schedule-queue model predicts outputs each cycle; directed literals pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_alu_ctrl_issue;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, stall, flush;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic [2:0] alu4, alu1;
  logic       v4, c4, b4, i4, v1, c1, b1, i1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MUL_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .stall_i(stall), .flush_i(flush), .ALUCtrl_o(alu4),
    .valid_o(v4), .commit_o(c4), .busy_o(b4), .illegal_o(i4)
  );

  alu_ctrl_issue #(.MUL_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .stall_i(stall), .flush_i(flush), .ALUCtrl_o(alu1),
    .valid_o(v1), .commit_o(c1), .busy_o(b1), .illegal_o(i1)
  );

  // ---------------- behavioural model ----------------
  // Output tuple {code, valid, commit, busy, illegal}
  typedef struct packed {
    logic [2:0] code;
    logic       vld;
    logic       com;
    logic       bsy;
    logic       ill;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    bit         f3_care;
    logic [6:0] f7;
    bit         f7_care;
    logic [2:0] code;
  } rule_t;

  rule_t rules[10];
  out_t  sched[2][$];   // cycles still to be shown for the instruction in flight
  out_t  mcur[2];       // what the outputs must be now
  int    mcyc[2];

  initial begin
    mcyc[0] = 4;
    mcyc[1] = 1;
    rules[0] = '{R,  3'b000, 1, 7'b0000000, 1, 3'b001};
    rules[1] = '{R,  3'b111, 1, 7'b0000000, 1, 3'b011};
    rules[2] = '{R,  3'b110, 1, 7'b0000000, 1, 3'b100};
    rules[3] = '{R,  3'b100, 1, 7'b0000000, 1, 3'b101};
    rules[4] = '{R,  3'b000, 1, 7'b0100000, 1, 3'b010};
    rules[5] = '{R,  3'b000, 1, 7'b0000001, 1, 3'b110};
    rules[6] = '{I,  3'b000, 1, 7'b0000000, 0, 3'b001};
    rules[7] = '{LD, 3'b000, 0, 7'b0000000, 0, 3'b001};
    rules[8] = '{ST, 3'b000, 0, 7'b0000000, 0, 3'b001};
    rules[9] = '{BR, 3'b000, 0, 7'b0000000, 0, 3'b010};
  end

  // Table lookup; returns {code, illegal}
  function automatic logic [3:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    for (int r = 0; r < 10; r++)
      if (rules[r].op == op && (!rules[r].f3_care || rules[r].f3 == f3) &&
          (!rules[r].f7_care || rules[r].f7 == f7))
        return {rules[r].code, 1'b0};
    return {3'b000, 1'b1};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        sched[k].delete();
        mcur[k] = '0;
      end else if (!stall) begin
        if (sched[k].size() > 0) begin
          mcur[k] = sched[k].pop_front();
        end else if (valid) begin
          logic [3:0] d;
          int n;
          d = ref_decode(opcode, funct3, funct7);
          n = (d[3:1] == 3'b110) ? mcyc[k] : 1;
          for (int c = 0; c < n; c++)
            sched[k].push_back('{d[3:1], 1'b1, c == n - 1, c < n - 1, d[0]});
          mcur[k] = sched[k].pop_front();
        end else begin
          mcur[k] = '0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Every cycle: both instances against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_mc4", {25'd0, alu4, v4, c4, b4, i4}, {25'd0, mcur[0]});
      chk("model_mc1", {25'd0, alu1, v1, c1, b1, i1}, {25'd0, mcur[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic st, input logic fl);
    valid = v; opcode = op; funct3 = f3; funct7 = f7; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7);
    drive(v, op, f3, f7, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 3'd0, 7'd0);
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] code;
  } vec_t;

  vec_t seq[9];
  int   n110, nbusy, ncom, nbusy1;

  initial begin
    seq[0] = '{R,  3'b000, 7'b0000000, 3'b001};  // add
    seq[1] = '{R,  3'b000, 7'b0100000, 3'b010};  // sub
    seq[2] = '{R,  3'b100, 7'b0000000, 3'b101};  // xor
    seq[3] = '{I,  3'b000, 7'b0101010, 3'b001};  // addi
    seq[4] = '{BR, 3'b000, 7'b0000000, 3'b010};  // beq
    seq[5] = '{R,  3'b111, 7'b0000000, 3'b011};  // and
    seq[6] = '{R,  3'b110, 7'b0000000, 3'b100};  // or
    seq[7] = '{LD, 3'b010, 7'b0000000, 3'b001};  // lw
    seq[8] = '{ST, 3'b010, 7'b1111111, 3'b001};  // sw

    rst = 1'b1;
    valid = 0; opcode = '0; funct3 = '0; funct7 = '0; stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    started = 1;

    // 1: asynchronous reset mid-cycle, then quiet idle
    step(1'b1, R, 3'b000, 7'b0000000);
    chk("pre_reset_add", {29'd0, alu4}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_mc4", {25'd0, alu4, v4, c4, b4, i4}, 32'd0);
    chk("async_reset_mc1", {25'd0, alu1, v1, c1, b1, i1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("idle_after_reset", {25'd0, alu4, v4, c4, b4, i4}, 32'd0);
    end

    // 2: single-cycle ops back to back
    for (int i = 0; i < 9; i++) begin
      step(1'b1, seq[i].op, seq[i].f3, seq[i].f7);
      chk("single_code", {29'd0, alu4}, {29'd0, seq[i].code});
      chk("single_vld_com", {30'd0, v4, c4}, 32'd3);
    end
    idle();

    // 3: mul, then add held by ID while busy
    n110 = 0; nbusy = 0; ncom = 0; nbusy1 = 0;
    step(1'b1, R, 3'b000, 7'b0000001);
    chk("mul1_code_mc1", {29'd0, alu1, c1}, {28'd0, 4'b1101});
    for (int i = 0; i < 4; i++) begin
      if (alu4 == 3'b110) n110++;
      if (b4) nbusy++;
      if (c4) ncom++;
      if (b1) nbusy1++;
      if (i < 3) chk("mul_no_early_commit", {31'd0, c4}, 32'd0);
      step(1'b1, R, 3'b000, 7'b0000000);
    end
    chk("mul_cycles", n110, 4);
    chk("mul_busy_cycles", nbusy, 3);
    chk("mul_commit_count", ncom, 1);
    chk("mul1_never_busy", nbusy1, 0);
    chk("add_after_mul", {29'd0, alu4}, 32'd1);
    chk("add_after_mul_vb", {30'd0, v4, b4}, 32'd2);
    idle();

    // 4: mul with a two-cycle stall in its second cycle
    n110 = 0; ncom = 0;
    step(1'b1, R, 3'b000, 7'b0000001);
    for (int i = 0; i < 6; i++) begin
      if (alu4 == 3'b110 && v4) n110++;
      if (c4) ncom++;
      drive(1'b0, 7'd0, 3'd0, 7'd0, (i < 2), 1'b0);
    end
    chk("stall_mul_cycles", n110, 6);
    chk("stall_mul_commits", ncom, 1);
    chk("stall_mul_done", {25'd0, alu4, v4, c4, b4, i4}, 32'd0);

    // 5: flush during mul with a valid input present
    step(1'b1, R, 3'b000, 7'b0000001);
    drive(1'b1, R, 3'b000, 7'b0000000, 1'b0, 1'b1);
    chk("flush_clears", {26'd0, alu4, v4, b4, c4}, 32'd0);
    idle();
    chk("flush_input_dropped", {31'd0, v4}, 32'd0);

    // 6: illegal encodings and flush-over-stall
    step(1'b1, R, 3'b000, 7'b1111111);
    chk("illegal_funct7", {28'd0, alu4, i4}, 32'd1);
    step(1'b1, 7'b1111111, 3'b000, 7'b0000000);
    chk("illegal_opcode", {28'd0, alu4, i4}, 32'd1);
    step(1'b1, R, 3'b001, 7'b0000001);
    chk("illegal_mul_f3", {28'd0, alu4, i4}, 32'd1);
    step(1'b1, I, 3'b001, 7'b0000000);
    chk("illegal_imm_f3", {26'd0, alu4, i4, v4, c4}, 32'd7);
    step(1'b1, R, 3'b000, 7'b0000000);
    chk("illegal_cleared", {28'd0, alu4, i4}, 32'd2);
    drive(1'b1, R, 3'b000, 7'b0000000, 1'b1, 1'b1);
    chk("flush_beats_stall", {28'd0, alu4, v4}, 32'd0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
